// File: rtl/n_w_en_pkg.sv
// n_w_en_pkg: shared types and one-hot helper for the bank write-enable sequencer.
package n_w_en_pkg;
    localparam int MAX_N = 6;
    typedef enum logic [1:0] {SINGLE = 2'd0, ALL = 2'd1, MASK = 2'd2, SWEEP = 2'd3} wen_mode_e;
    typedef enum logic {IDLE = 1'b0, BEAT = 1'b1} state_e;
    function automatic logic [2**MAX_N-1:0] onehot(input logic [MAX_N-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/n_w_en_seq_bank_onehot_dec.sv
// bank_onehot_dec: N-to-2**N bank decoder (N up to MAX_N).
module bank_onehot_dec
    import n_w_en_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [N-1:0]    idx,
    output logic [2**N-1:0] oh
);
    localparam int NB = 2**N;
    assign oh = NB'(onehot(MAX_N'(idx)));
endmodule

// File: rtl/n_w_en_seq.sv
// n_w_en_seq: sequenced bank write-enable generator (single/all/mask/strided sweep).
// Define N_W_EN_STRIDE_EN to add a programmable sweep stride port.
module n_w_en_seq
    import n_w_en_pkg::*;
#(
    parameter int N = 1
`ifdef N_W_EN_STRIDE_EN
    , parameter int STRIDE_W = N
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  wen_mode_e       mode,
    input  logic [N-1:0]    sel,
    input  logic [N-1:0]    cnt,
    input  logic [2**N-1:0] mask,
    input  logic            stall,
    input  logic            abort,
    output logic [2**N-1:0] w_en_out,
    output logic [N-1:0]    bank_idx,
    output logic            busy,
    output logic            done
`ifdef N_W_EN_STRIDE_EN
    , input logic [STRIDE_W-1:0] stride
`endif
);
    state_e          state_q, state_d;
    logic [2**N-1:0] beat_q, beat_d, oh_sel, oh_nxt;
    logic [N-1:0]    idx_q, idx_d, rem_q, rem_d, idx_nxt, step;
    logic            active, go, accept;

    bank_onehot_dec #(.N(N)) u_dec_sel (.idx(sel), .oh(oh_sel));
    bank_onehot_dec #(.N(N)) u_dec_nxt (.idx(idx_nxt), .oh(oh_nxt));

`ifdef N_W_EN_STRIDE_EN
    logic [N-1:0] step_q;
    // Stride is latched at accept so the sweep is immune to later port changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step_q <= N'(1);
        else if (accept && mode == SWEEP)
            step_q <= (stride == '0) ? N'(1) : N'(stride);
    end
    assign step = step_q;
`else
    assign step = N'(1);
`endif

    assign idx_nxt   = idx_q + step;
    assign active    = (state_q == BEAT);
    assign go        = !stall && !abort;
    assign w_en_out  = (active && go) ? beat_q : '0;
    assign done      = active && go && (rem_q == '0);
    assign busy      = active;
    assign bank_idx  = active ? idx_q : '0;
    assign req_ready = (!active || done) && !abort;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        if (accept) begin
            state_d = BEAT;
            idx_d   = sel;
            beat_d  = (mode == ALL) ? '1 : (mode == MASK) ? mask : oh_sel;
            rem_d   = (mode == SWEEP) ? cnt : '0;
        end else if (active && (abort || (!stall && rem_q == '0))) begin
            state_d = IDLE;
            beat_d  = '0;
        end else if (active && !stall) begin
            idx_d  = idx_nxt;
            beat_d = oh_nxt;
            rem_d  = rem_q - N'(1);
        end
    end
endmodule

// File: tb/tb_n_w_en_seq.sv
// tb_n_w_en_seq: directed checks of the bank write-enable sequencer at N=2.
module tb_n_w_en_seq;
    import n_w_en_pkg::*;

    logic       clk, rst_n, req_valid, stall, abort;
    wen_mode_e  mode;
    logic [1:0] sel, cnt, bank_idx;
    logic [3:0] mask, w_en_out;
    logic       req_ready, busy, done;
    logic [8:0] obs;
    int         checks = 0;
    int         failures = 0;
`ifdef N_W_EN_STRIDE_EN
    logic [1:0] stride;
`endif

    n_w_en_seq #(
        .N(2)
`ifdef N_W_EN_STRIDE_EN
        , .STRIDE_W(2)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mode(mode), .sel(sel), .cnt(cnt), .mask(mask), .stall(stall), .abort(abort),
        .w_en_out(w_en_out), .bank_idx(bank_idx), .busy(busy), .done(done)
`ifdef N_W_EN_STRIDE_EN
        , .stride(stride)
`endif
    );

    // obs = {w_en_out, bank_idx, busy, done, req_ready}
    assign obs = {w_en_out, bank_idx, busy, done, req_ready};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        req_valid = 0; mode = SINGLE; sel = 0; cnt = 0; mask = 0; stall = 0; abort = 0;
`ifdef N_W_EN_STRIDE_EN
        stride = 0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs();
        #3;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL reset_state got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
        @(negedge clk); @(negedge clk); rst_n = 1; #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
    endtask

    task automatic test_single();
        @(negedge clk); req_valid = 1; mode = SINGLE; sel = 2; #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL single_t0 got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 9'b0100_10_1_1_1) begin failures++; $display("FAIL single_t1 got=%b exp=%b", obs, 9'b0100_10_1_1_1); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL single_t2 got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
    endtask

    task automatic test_sweep();
        @(negedge clk); req_valid = 1; mode = SWEEP; sel = 3; cnt = 2; #1;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 9'b1000_11_1_0_0) begin failures++; $display("FAIL sweep_b0 got=%b exp=%b", obs, 9'b1000_11_1_0_0); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0001_00_1_0_0) begin failures++; $display("FAIL sweep_b1_wrap got=%b exp=%b", obs, 9'b0001_00_1_0_0); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0010_01_1_1_1) begin failures++; $display("FAIL sweep_b2_done got=%b exp=%b", obs, 9'b0010_01_1_1_1); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL sweep_idle got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
    endtask

    task automatic test_stall();
        @(negedge clk); req_valid = 1; mode = SWEEP; sel = 3; cnt = 2; #1;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 9'b1000_11_1_0_0) begin failures++; $display("FAIL stall_b0 got=%b exp=%b", obs, 9'b1000_11_1_0_0); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); stall = 1; #1;
            checks++; if (obs !== 9'b0000_00_1_0_0) begin failures++; $display("FAIL stall_hold%0d got=%b exp=%b", i, obs, 9'b0000_00_1_0_0); end
        end
        @(negedge clk); stall = 0; #1;
        checks++; if (obs !== 9'b0001_00_1_0_0) begin failures++; $display("FAIL stall_retry got=%b exp=%b", obs, 9'b0001_00_1_0_0); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0010_01_1_1_1) begin failures++; $display("FAIL stall_done got=%b exp=%b", obs, 9'b0010_01_1_1_1); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL stall_idle got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); req_valid = 1; mode = ALL; sel = 0; #1;
        @(negedge clk); mode = MASK; mask = 4'b1010; #1;
        checks++; if (obs !== 9'b1111_00_1_1_1) begin failures++; $display("FAIL b2b_all got=%b exp=%b", obs, 9'b1111_00_1_1_1); end
        @(negedge clk); mask = 4'b0000; #1;
        checks++; if (obs !== 9'b1010_00_1_1_1) begin failures++; $display("FAIL b2b_mask got=%b exp=%b", obs, 9'b1010_00_1_1_1); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 9'b0000_00_1_1_1) begin failures++; $display("FAIL b2b_mask_zero got=%b exp=%b", obs, 9'b0000_00_1_1_1); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL b2b_idle got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
    endtask

    task automatic test_abort();
        @(negedge clk); req_valid = 1; mode = SWEEP; sel = 0; cnt = 3; #1;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 9'b0001_00_1_0_0) begin failures++; $display("FAIL abort_b0 got=%b exp=%b", obs, 9'b0001_00_1_0_0); end
        @(negedge clk); abort = 1; req_valid = 1; mode = SINGLE; sel = 1; #1;
        checks++; if (obs !== 9'b0000_01_1_0_0) begin failures++; $display("FAIL abort_cycle got=%b exp=%b", obs, 9'b0000_01_1_0_0); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); #1;
            checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL abort_idle%0d got=%b exp=%b", i, obs, 9'b0000_00_0_0_1); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); req_valid = 1; mode = SWEEP; sel = 0; cnt = 3; #1;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 9'b0001_00_1_0_0) begin failures++; $display("FAIL rstmid_b0 got=%b exp=%b", obs, 9'b0001_00_1_0_0); end
        @(negedge clk); #2; rst_n = 0; #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL rstmid_async got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
        @(negedge clk); rst_n = 1; #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL rstmid_release got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
        @(negedge clk); req_valid = 1; mode = SINGLE; sel = 1; #1;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 9'b0010_01_1_1_1) begin failures++; $display("FAIL rstmid_single got=%b exp=%b", obs, 9'b0010_01_1_1_1); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL rstmid_idle got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
    endtask

`ifdef N_W_EN_STRIDE_EN
    task automatic test_stride();
        @(negedge clk); req_valid = 1; mode = SWEEP; sel = 1; cnt = 3; stride = 2; #1;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (obs !== 9'b0010_01_1_0_0) begin failures++; $display("FAIL stride_b0 got=%b exp=%b", obs, 9'b0010_01_1_0_0); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b1000_11_1_0_0) begin failures++; $display("FAIL stride_b1 got=%b exp=%b", obs, 9'b1000_11_1_0_0); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0010_01_1_0_0) begin failures++; $display("FAIL stride_b2 got=%b exp=%b", obs, 9'b0010_01_1_0_0); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b1000_11_1_1_1) begin failures++; $display("FAIL stride_b3 got=%b exp=%b", obs, 9'b1000_11_1_1_1); end
        @(negedge clk); #1;
        checks++; if (obs !== 9'b0000_00_0_0_1) begin failures++; $display("FAIL stride_idle got=%b exp=%b", obs, 9'b0000_00_0_0_1); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef N_W_EN_STRIDE_EN
        test_stride();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
